q_cal_scheduler: RTL

Q_CAL_SCHEDULER -- requirements
Module: q_cal_scheduler

---
 rtl/q_cal_scheduler_if.sv | 33 +++
 rtl/q_cal_scheduler.sv | 136 +++++++++++++
 2 files changed

// File: rtl/q_cal_scheduler_if.sv
// Bus between the Q-calculation scheduler and its requesters/datapath.
//
// Handshake: req[k] is a level request with no ready; the scheduler answers
// with a one-cycle grant[k] pulse (issue and sel coincide with it). The
// datapath returns q_in PIPE_LAT cycles after issue with no backpressure;
// q_valid is a one-cycle strobe qualifying q_out/q_ch.
interface q_cal_scheduler_if #(
  parameter int N_CH = 4,
  parameter int CW   = 2
);
  logic [N_CH-1:0] req;
  logic [N_CH-1:0] grant;
  logic [CW-1:0]   sel;
  logic            issue;
  logic [31:0]     q_in;
  logic [31:0]     q_out;
  logic            q_valid;
  logic [CW-1:0]   q_ch;
  logic            busy;
  logic [N_CH-1:0] inflight;

  // Requester/datapath side.
  modport master (
    output req, q_in,
    input  grant, sel, issue, q_out, q_valid, q_ch, busy, inflight
  );

  // Scheduler side.
  modport slave (
    input  req, q_in,
    output grant, sel, issue, q_out, q_valid, q_ch, busy, inflight
  );
endinterface

// File: rtl/q_cal_scheduler.sv
// Round-robin scheduler sharing one fixed-latency Q-calculation pipeline
// among N_CH requesters. A tag pipeline tracks which channel owns each
// result so the returning q_in can be labelled and strobed.
//
// Optional feature: define Q_SCHED_INFLIGHT_LOCK_EN to allow at most one
// outstanding result per channel (channels with a result in flight are
// masked from arbitration). Without it, inflight is tied to 0.
module q_cal_scheduler #(
  parameter int N_CH     = 4,
  parameter int CW       = 2,
  parameter int PIPE_LAT = 31
) (
  input  logic             clk,
  input  logic             rst,
  q_cal_scheduler_if.slave bus
);

  logic [CW-1:0]   ptr;
  logic [N_CH-1:0] eligible;
  logic            win_v;
  logic [CW-1:0]   win_idx;
  logic [CW-1:0]   ptr_next;

  logic [N_CH-1:0] grant_q;
  logic [CW-1:0]   sel_q;
  logic            issue_q;

  logic [PIPE_LAT-1:0] tag_v;
  logic [CW-1:0]       tag_ch [PIPE_LAT];

  logic [31:0]     q_out_q;
  logic            q_valid_q;
  logic [CW-1:0]   q_ch_q;

`ifdef Q_SCHED_INFLIGHT_LOCK_EN
  logic [N_CH-1:0] inflight_q;
  logic [N_CH-1:0] inflight_set;
  logic [N_CH-1:0] inflight_clr;

  // Channels with a result still in the pipeline are not eligible.
  always_comb begin
    eligible     = bus.req & ~inflight_q;
    inflight_set = win_v ? (N_CH'(1) << win_idx) : '0;
    inflight_clr = tag_v[PIPE_LAT-1] ? (N_CH'(1) << tag_ch[PIPE_LAT-1]) : '0;
  end

  // Flag sets with the grant and clears when the result is strobed out.
  always_ff @(posedge clk) begin
    if (rst) inflight_q <= '0;
    else     inflight_q <= (inflight_q & ~inflight_clr) | inflight_set;
  end

  assign bus.inflight = inflight_q;
`else
  // Every requesting channel competes every cycle.
  always_comb begin
    eligible = bus.req;
  end

  assign bus.inflight = '0;
`endif

  // Round-robin search starting at ptr, wrapping N_CH-1 to 0.
  always_comb begin
    int idx;
    idx     = 0;
    win_v   = 1'b0;
    win_idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      idx = (int'(ptr) + i) % N_CH;
      if (!win_v && eligible[idx]) begin
        win_v   = 1'b1;
        win_idx = CW'(idx);
      end
    end
    ptr_next = (int'(win_idx) == N_CH - 1) ? '0 : win_idx + CW'(1);
  end

  // Registered grant/issue/sel; pointer advances past the winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q <= '0;
      issue_q <= 1'b0;
      sel_q   <= '0;
      ptr     <= '0;
    end else begin
      grant_q <= win_v ? (N_CH'(1) << win_idx) : '0;
      issue_q <= win_v;
      if (win_v) begin
        sel_q <= win_idx;
        ptr   <= ptr_next;
      end
    end
  end

  // Tag pipeline mirrors the datapath latency, carrying {issue, sel}.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        tag_v[i]  <= 1'b0;
        tag_ch[i] <= '0;
      end
    end else begin
      tag_v[0]  <= issue_q;
      tag_ch[0] <= sel_q;
      for (int i = 1; i < PIPE_LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_ch[i] <= tag_ch[i-1];
      end
    end
  end

  // Capture the datapath result when its tag reaches the end; hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_out_q   <= '0;
      q_ch_q    <= '0;
      q_valid_q <= 1'b0;
    end else begin
      q_valid_q <= tag_v[PIPE_LAT-1];
      if (tag_v[PIPE_LAT-1]) begin
        q_out_q <= bus.q_in;
        q_ch_q  <= tag_ch[PIPE_LAT-1];
      end
    end
  end

  assign bus.grant   = grant_q;
  assign bus.sel     = sel_q;
  assign bus.issue   = issue_q;
  assign bus.q_out   = q_out_q;
  assign bus.q_valid = q_valid_q;
  assign bus.q_ch    = q_ch_q;
  assign bus.busy    = issue_q | (|tag_v);

endmodule
